cva6_cfg_descriptor_streamer: RTL

// - Read-out side of the core configuration: streams a snapshot of flattened config descriptor

---
 rtl/cva6_cfg_descriptor_streamer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/cva6_cfg_descriptor_streamer.sv
// Streams a snapshot of the flattened configuration descriptor image over valid/ready,
// terminated by an XOR checksum beat. All stream outputs are registered.
module cva6_cfg_descriptor_streamer #(
    parameter int unsigned        NUM_WORDS = 16,
    parameter int unsigned        DATA_W    = 64,
    parameter logic [DATA_W-1:0]  CSUM_SEED = '0,
    localparam int unsigned       IDX_W     = $clog2(NUM_WORDS)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_WORDS*DATA_W-1:0] cfg_words_i,
    input  logic                        start_i,
    input  logic [IDX_W-1:0]            start_idx_i,
    input  logic [IDX_W:0]              count_i,
    input  logic                        abort_i,
    output logic                        tvalid_o,
    input  logic                        tready_i,
    output logic [DATA_W-1:0]           tdata_o,
    output logic [IDX_W-1:0]            tidx_o,
    output logic                        tcsum_o,
    output logic                        tlast_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        aborted_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_CSUM = 2'd2
    } state_t;

    state_t                        r_state;
    logic [NUM_WORDS*DATA_W-1:0]   r_snap;
    logic [IDX_W-1:0]              r_idx;
    logic [IDX_W:0]                r_rem;
    logic [DATA_W-1:0]             r_acc;
    logic                          r_tvalid;
    logic [DATA_W-1:0]             r_tdata;
    logic [IDX_W-1:0]              r_tidx;
    logic                          r_tcsum;
    logic                          r_done;
    logic                          r_aborted;

    logic                          w_hs;
    logic [IDX_W:0]                w_count;
    logic [DATA_W-1:0]             w_start_word;
    logic [DATA_W-1:0]             w_snap_word;
    logic [DATA_W-1:0]             w_acc_next;

    assign w_hs         = r_tvalid & tready_i;
    assign w_count      = (count_i == '0) ? (IDX_W+1)'(NUM_WORDS) : count_i;
    assign w_start_word = cfg_words_i[start_idx_i*DATA_W +: DATA_W];
    assign w_snap_word  = r_snap[r_idx*DATA_W +: DATA_W];
    assign w_acc_next   = r_acc ^ r_tdata;

    // r_idx always points at the word following the one currently presented,
    // and r_rem counts the presented word too, so rem==1 marks the last data beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_snap    <= '0;
            r_idx     <= '0;
            r_rem     <= '0;
            r_acc     <= '0;
            r_tvalid  <= 1'b0;
            r_tdata   <= '0;
            r_tidx    <= '0;
            r_tcsum   <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start_i && !abort_i) begin
                        r_snap   <= cfg_words_i;
                        r_idx    <= start_idx_i + 1'b1;
                        r_rem    <= w_count;
                        r_acc    <= CSUM_SEED;
                        r_tvalid <= 1'b1;
                        r_tdata  <= w_start_word;
                        r_tidx   <= start_idx_i;
                        r_tcsum  <= 1'b0;
                        r_state  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (abort_i) begin
                        r_tvalid  <= 1'b0;
                        r_tdata   <= '0;
                        r_tidx    <= '0;
                        r_tcsum   <= 1'b0;
                        r_aborted <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else if (w_hs) begin
                        r_acc <= w_acc_next;
                        if (r_rem == (IDX_W+1)'(1)) begin
                            r_tdata <= w_acc_next;
                            r_tidx  <= '0;
                            r_tcsum <= 1'b1;
                            r_state <= ST_CSUM;
                        end else begin
                            r_tdata <= w_snap_word;
                            r_tidx  <= r_idx;
                            r_idx   <= r_idx + 1'b1;
                            r_rem   <= r_rem - 1'b1;
                        end
                    end
                end
                ST_CSUM: begin
                    if (abort_i || w_hs) begin
                        r_tvalid  <= 1'b0;
                        r_tdata   <= '0;
                        r_tidx    <= '0;
                        r_tcsum   <= 1'b0;
                        r_done    <= ~abort_i;
                        r_aborted <= abort_i;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_tvalid <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign tvalid_o  = r_tvalid;
    assign tdata_o   = r_tdata;
    assign tidx_o    = r_tidx;
    assign tcsum_o   = r_tcsum;
    assign tlast_o   = r_tcsum;
    assign busy_o    = (r_state != ST_IDLE);
    assign done_o    = r_done;
    assign aborted_o = r_aborted;

endmodule
